// File: rtl/reg_file.sv
// RV32I integer register file: two combinational read ports, one write port,
// x0 hardwired to zero, x2 reset to the initial stack pointer, optional write-to-read bypass.
module reg_file #(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 5,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_0FFC,
    parameter int              BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD3,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Entry 0 has no storage at all; every read of address 0 is forced to zero below.
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    logic write_live;
    logic hit1;
    logic hit2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else if (WE3 && (A3 != '0)) begin
            regs[A3] <= WD3;
        end
    end

    // A write only forwards when it will actually land at the coming edge.
    assign write_live = WE3 && !rst && (A3 != '0);
    assign hit1       = (BYPASS != 0) && write_live && (A3 == A1);
    assign hit2       = (BYPASS != 0) && write_live && (A3 == A2);

    assign RD1      = (A1 == '0)       ? '0 : (hit1 ? WD3 : regs[A1]);
    assign RD2      = (A2 == '0)       ? '0 : (hit2 ? WD3 : regs[A2]);
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: one bypassing and one non-bypassing instance share stimulus;
// expected values are queued by the stimulus and popped by a negedge monitor.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we3;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [4:0]  dbg_addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] dbg_data;
    logic [31:0] rd1_nb;
    logic [31:0] rd2_nb;
    logic [31:0] dbg_data_nb;

    typedef struct {
        logic [5:0]  mask;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] dbg;
        logic [31:0] rd1_nb;
        logic [31:0] rd2_nb;
        int          tag;
    } exp_t;

    exp_t        sb_q[$];
    int          checks;
    int          errors;
    int          tag;
    logic [31:0] model [0:31];

    localparam logic [5:0] M_ALL = 6'b111111;
    localparam logic [5:0] M_DBG = 6'b100100;

    reg_file #(.DATA_W(32), .ADDR_W(5), .SP_INIT(32'h0000_0FFC), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .WE3(we3), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3),
        .RD1(rd1), .RD2(rd2), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    reg_file #(.DATA_W(32), .ADDR_W(5), .SP_INIT(32'h0000_0FFC), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .WE3(we3), .A1(a1), .A2(a2), .A3(a3), .WD3(wd3),
        .RD1(rd1_nb), .RD2(rd2_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input int t, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s tag%0d: got %h, expected %h", name, t, act, exp);
        end
    endtask

    // Monitor: the register file answers combinationally, so each cycle's response is taken mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.mask[0]) compare("rd1", e.tag, rd1, e.rd1);
            if (e.mask[1]) compare("rd2", e.tag, rd2, e.rd2);
            if (e.mask[2]) compare("dbg_data", e.tag, dbg_data, e.dbg);
            if (e.mask[3]) compare("rd1_nobypass", e.tag, rd1_nb, e.rd1_nb);
            if (e.mask[4]) compare("rd2_nobypass", e.tag, rd2_nb, e.rd2_nb);
            if (e.mask[5]) compare("dbg_data_nobypass", e.tag, dbg_data_nb, e.dbg);
        end
    end

    // The inputs held through the last edge are folded into the model before new ones are driven.
    task automatic apply_stimulus(input logic r, input logic we, input logic [4:0] wa,
                                  input logic [31:0] wd, input logic [4:0] ra1,
                                  input logic [4:0] ra2, input logic [4:0] da);
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = (i == 2) ? 32'h0000_0FFC : 32'h0;
        end else if (we3 && a3 != 5'd0) begin
            model[a3] = wd3;
        end
        rst      = r;
        we3      = we;
        a3       = wa;
        wd3      = wd;
        a1       = ra1;
        a2       = ra2;
        dbg_addr = da;
        tag++;
    endtask

    task automatic check_output(input logic [5:0] mask, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] ed,
                                input logic [31:0] e1n, input logic [31:0] e2n);
        exp_t e;
        e.mask   = mask;
        e.rd1    = e1;
        e.rd2    = e2;
        e.dbg    = ed;
        e.rd1_nb = e1n;
        e.rd2_nb = e2n;
        e.tag    = tag;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] addr, input logic bypass);
        if (addr == 5'd0) return 32'h0;
        if (bypass && we3 && !rst && a3 == addr) return wd3;
        return model[addr];
    endfunction

    initial begin
        logic [31:0] e_sp;
        logic [31:0] e_other;
        checks   = 0;
        errors   = 0;
        tag      = 0;
        rst      = 1'b0;
        we3      = 1'b0;
        a1       = '0;
        a2       = '0;
        a3       = '0;
        wd3      = '0;
        dbg_addr = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Reset image: everything zero apart from the stack pointer.
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 5'(i));
            e_sp    = (i == 2) ? 32'h0000_0FFC : 32'h0;
            e_other = ((31 - i) == 2) ? 32'h0000_0FFC : 32'h0;
            check_output(M_ALL, e_sp, e_other, e_sp, e_sp, e_other);
        end

        apply_stimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd5);
        check_output(M_DBG, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5);
        check_output(M_ALL, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        apply_stimulus(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        check_output(M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
        check_output(M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        apply_stimulus(1'b0, 1'b1, 5'd7, 32'h0000_0001, 5'd0, 5'd0, 5'd7);
        check_output(M_DBG, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b1, 5'd7, 32'h0000_00AA, 5'd7, 5'd3, 5'd7);
        check_output(M_ALL, 32'h0000_00AA, 32'h0, 32'h0000_0001, 32'h0000_0001, 32'h0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 5'd7);
        check_output(M_ALL, 32'h0000_00AA, 32'h0000_00AA, 32'h0000_00AA, 32'h0000_00AA, 32'h0000_00AA);

        // Reset racing a write: no forwarding during reset, and the write must not land.
        apply_stimulus(1'b0, 1'b1, 5'd9, 32'h0000_0055, 5'd0, 5'd0, 5'd9);
        check_output(M_DBG, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd2, 5'd9);
        check_output(M_ALL, 32'h0000_0055, 32'h0000_0FFC, 32'h0000_0055, 32'h0000_0055, 32'h0000_0FFC);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, 5'd9);
        check_output(M_ALL, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd2, 5'd7);
        check_output(M_ALL, 32'h0, 32'h0000_0FFC, 32'h0, 32'h0, 32'h0000_0FFC);

        apply_stimulus(1'b0, 1'b1, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd12, 5'd12);
        check_output(M_ALL, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 5'd12);
        check_output(M_ALL, 32'hCAFE_F00D, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0);

        for (int n = 0; n < 2000; n++) begin
            apply_stimulus(($urandom_range(0, 49) == 0), 1'($urandom), 5'($urandom),
                           $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
            if (n % 7 == 0) a1 = a3;
            if (n % 11 == 0) a2 = a3;
            check_output(M_ALL, model_read(a1, 1'b1), model_read(a2, 1'b1),
                         model_read(dbg_addr, 1'b0), model_read(a1, 1'b0),
                         model_read(a2, 1'b0));
        end

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
